// File: rtl/jt900h_intc.sv
// jt900h_intc: eight-source, edge-triggered interrupt controller with
// per-source enable, 3-bit priority level and a programmable vector base.
// The CPU bus inserts exactly one wait state per access.
module jt900h_intc (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic [1:0]  we,
  input  logic        rd,
  output logic        busy,
  input  logic [7:0]  src,
  output logic        irq,
  input  logic        irq_ack,
  output logic [2:0]  int_lvl,
  output logic [7:0]  int_addr
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned LW   = 3;
  localparam int unsigned DW   = 16;
  localparam int unsigned IW   = 3;
  localparam int unsigned VW   = 8;

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_EN    = 3'd1;
  localparam logic [2:0] A_LVLLO = 3'd2;
  localparam logic [2:0] A_LVLHI = 3'd3;
  localparam logic [2:0] A_VBASE = 3'd4;
  localparam logic [2:0] A_STAT  = 3'd5;

  // Registered state
  logic                       ack_q,     ack_d;
  logic [DW-1:0]              dout_q,    dout_d;
  logic [NSRC-1:0]            pend_q,    pend_d;
  logic [NSRC-1:0]            en_q,      en_d;
  logic [NSRC-1:0][LW-1:0]    lvl_q,     lvl_d;
  logic [2:0]                 vbase_q,   vbase_d;
  logic [IW-1:0]              svc_idx_q, svc_idx_d;
  logic [LW-1:0]              svc_lvl_q, svc_lvl_d;
  logic [NSRC-1:0]            src_q,     src_d;
  logic [NSRC-1:0]            edge_q,    edge_d;
  logic                       first_q,   first_d;
  logic                       irq_q,     irq_d;
  logic [LW-1:0]              int_lvl_q, int_lvl_d;
  logic [VW-1:0]              int_addr_q, int_addr_d;

  // Combinational helpers
  logic                       access_c;
  logic                       commit_c;
  logic                       wr_lo_c;
  logic                       wr_hi_c;
  logic [DW-1:0]              rdata_c;
  logic                       ack_hit_c;
  logic [IW-1:0]              out_idx_c;
  logic [NSRC-1:0]            ack_mask_c;
  logic [NSRC-1:0]            clr_c;
  logic [NSRC-1:0]            cand_c;
  logic                       win_vld_c;
  logic [IW-1:0]              win_idx_c;
  logic [LW-1:0]              win_lvl_c;
  logic                       unused_c;

  // Bus handshake: one wait state until ack_q is set, commit on the next cen
  always_comb begin
    access_c = cs & (rd | (|we));
    busy     = access_c & ~ack_q;
    commit_c = access_c & ack_q;
    wr_lo_c  = commit_c & we[0];
    wr_hi_c  = commit_c & we[1];
    ack_d    = access_c;
  end

  // Read data multiplexer
  always_comb begin
    rdata_c = '0;
    case (addr)
      A_PEND:  rdata_c = {8'h00, pend_q};
      A_EN:    rdata_c = {8'h00, en_q};
      A_LVLLO: rdata_c = {1'b0, lvl_q[3], 1'b0, lvl_q[2], 1'b0, lvl_q[1], 1'b0, lvl_q[0]};
      A_LVLHI: rdata_c = {1'b0, lvl_q[7], 1'b0, lvl_q[6], 1'b0, lvl_q[5], 1'b0, lvl_q[4]};
      A_VBASE: rdata_c = {8'h00, vbase_q, 5'b00000};
      A_STAT:  rdata_c = {8'h00, irq_q, svc_idx_q, svc_lvl_q, 1'b0};
      default: rdata_c = '0;
    endcase
    dout_d = commit_c ? rdata_c : dout_q;
  end

  // Configuration register writes, honouring byte enables
  always_comb begin
    en_d    = en_q;
    lvl_d   = lvl_q;
    vbase_d = vbase_q;
    if (wr_lo_c && addr == A_EN) begin
      en_d = din[7:0];
    end
    if (wr_lo_c && addr == A_LVLLO) begin
      lvl_d[0] = din[2:0];
      lvl_d[1] = din[6:4];
    end
    if (wr_hi_c && addr == A_LVLLO) begin
      lvl_d[2] = din[10:8];
      lvl_d[3] = din[14:12];
    end
    if (wr_lo_c && addr == A_LVLHI) begin
      lvl_d[4] = din[2:0];
      lvl_d[5] = din[6:4];
    end
    if (wr_hi_c && addr == A_LVLHI) begin
      lvl_d[6] = din[10:8];
      lvl_d[7] = din[14:12];
    end
    if (wr_lo_c && addr == A_VBASE) begin
      vbase_d = din[7:5];
    end
  end

  // Edge detection; the first cen cycle after reset only primes src_q
  always_comb begin
    src_d   = src;
    edge_d  = first_q ? '0 : (src & ~src_q);
    first_d = 1'b0;
  end

  // Pending bits: write-1-clear and acknowledge clear, a new edge always wins
  always_comb begin
    ack_hit_c  = irq_ack & irq_q;
    out_idx_c  = int_addr_q[4:2];
    ack_mask_c = ack_hit_c ? (8'd1 << out_idx_c) : 8'h00;
    clr_c      = ack_mask_c;
    if (wr_lo_c && addr == A_PEND) begin
      clr_c = clr_c | din[7:0];
    end
    pend_d = (pend_q & ~clr_c) | edge_q;
  end

  // Arbitration: highest level wins, lowest index breaks ties
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    win_lvl_c = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      cand_c[i] = pend_q[i] & en_q[i] & (lvl_q[i] != '0) & ~ack_mask_c[i];
    end
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (cand_c[i] && lvl_q[i] > win_lvl_c) begin
        win_vld_c = 1'b1;
        win_idx_c = IW'(i);
        win_lvl_c = lvl_q[i];
      end
    end
  end

  // Interrupt outputs and service latch
  always_comb begin
    irq_d      = win_vld_c;
    int_lvl_d  = win_vld_c ? win_lvl_c : '0;
    int_addr_d = win_vld_c ? {vbase_q, win_idx_c, 2'b00} : int_addr_q;
    svc_idx_d  = svc_idx_q;
    svc_lvl_d  = svc_lvl_q;
    if (ack_hit_c) begin
      svc_idx_d = out_idx_c;
      svc_lvl_d = int_lvl_q;
    end
  end

  // State registers: reset overrides cen, otherwise advance only on cen
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= 1'b0;
      dout_q     <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      lvl_q      <= '0;
      vbase_q    <= '0;
      svc_idx_q  <= '0;
      svc_lvl_q  <= '0;
      src_q      <= '0;
      edge_q     <= '0;
      first_q    <= 1'b1;
      irq_q      <= 1'b0;
      int_lvl_q  <= '0;
      int_addr_q <= '0;
    end else if (cen) begin
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      lvl_q      <= lvl_d;
      vbase_q    <= vbase_d;
      svc_idx_q  <= svc_idx_d;
      svc_lvl_q  <= svc_lvl_d;
      src_q      <= src_d;
      edge_q     <= edge_d;
      first_q    <= first_d;
      irq_q      <= irq_d;
      int_lvl_q  <= int_lvl_d;
      int_addr_q <= int_addr_d;
    end
  end

  // Data bits that map to no register field
  assign unused_c = ^{din[15], din[11]};

  assign dout     = dout_q;
  assign irq      = irq_q;
  assign int_lvl  = int_lvl_q;
  assign int_addr = int_addr_q;

endmodule

// File: tb/tb_jt900h_intc.sv
// Bench for jt900h_intc: directed scenarios plus randomized traffic, all
// checked by a scoreboard fed from a behavioural reference model.
module tb_jt900h_intc;

  logic        clk = 1'b0;
  logic        rst, cen, cs, rd, irq_ack;
  logic [2:0]  addr;
  logic [15:0] din;
  logic [1:0]  we;
  logic [7:0]  src;
  logic [15:0] dout;
  logic        busy, irq;
  logic [2:0]  int_lvl;
  logic [7:0]  int_addr;

  jt900h_intc dut (
    .rst(rst), .clk(clk), .cen(cen), .cs(cs), .addr(addr), .din(din),
    .dout(dout), .we(we), .rd(rd), .busy(busy), .src(src), .irq(irq),
    .irq_ack(irq_ack), .int_lvl(int_lvl), .int_addr(int_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit bench_done = 1'b0;
  bit rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] m_pend, m_en, m_prev, m_edge, m_newp;
  int       m_lvl [8];
  int       m_vbase, m_svc_idx, m_svc_lvl, m_ilvl, m_iaddr, m_dout, m_cur, m_best;
  bit       m_first, m_ack, m_irq, m_access, m_commit, m_ackhit;

  logic [15:0] rd_q [$];
  logic [27:0] st_q [$];

  function automatic int reg_read(input int a);
    case (a)
      0: return int'(m_pend);
      1: return int'(m_en);
      2: return m_lvl[0] + m_lvl[1] * 16 + m_lvl[2] * 256 + m_lvl[3] * 4096;
      3: return m_lvl[4] + m_lvl[5] * 16 + m_lvl[6] * 256 + m_lvl[7] * 4096;
      4: return m_vbase * 32;
      5: return int'(m_irq) * 128 + m_svc_idx * 16 + m_svc_lvl * 2;
      default: return 0;
    endcase
  endfunction

  // Model steps once per clock from the same input values the DUT sees
  always @(posedge clk) begin
    m_access = cs && (rd || we != 2'b00);
    if (rst) begin
      m_pend = '0; m_en = '0; m_prev = '0; m_edge = '0;
      for (int i = 0; i < 8; i++) m_lvl[i] = 0;
      m_vbase = 0; m_svc_idx = 0; m_svc_lvl = 0;
      m_ilvl = 0; m_iaddr = 0; m_dout = 0;
      m_first = 1'b1; m_ack = 1'b0; m_irq = 1'b0;
      st_q.push_back({16'(m_dout), m_irq, 3'(m_ilvl), 8'(m_iaddr)});
    end else if (cen) begin
      m_commit = m_access && m_ack;
      m_cur    = (m_iaddr / 4) % 8;
      m_ackhit = irq_ack && m_irq;
      if (m_commit) begin
        m_dout = reg_read(int'(addr));
        rd_q.push_back(16'(m_dout));
      end
      // pick the best eligible source, ignoring the one being acknowledged
      m_best = -1;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i] && m_en[i] && m_lvl[i] != 0 && !(m_ackhit && i == m_cur)) begin
          if (m_best < 0 || m_lvl[i] > m_lvl[m_best]) m_best = i;
        end
      end
      m_newp = m_pend;
      if (m_commit && addr == 3'd0 && we[0]) m_newp = m_newp & ~din[7:0];
      if (m_ackhit) begin
        m_newp[m_cur] = 1'b0;
        m_svc_idx = m_cur;
        m_svc_lvl = m_ilvl;
      end
      m_newp = m_newp | m_edge;
      if (m_best >= 0) begin
        m_irq = 1'b1; m_ilvl = m_lvl[m_best]; m_iaddr = m_vbase * 32 + m_best * 4;
      end else begin
        m_irq = 1'b0; m_ilvl = 0;
      end
      if (m_commit) begin
        case (addr)
          3'd1: if (we[0]) m_en = din[7:0];
          3'd2: begin
            if (we[0]) begin m_lvl[0] = int'(din[2:0]);  m_lvl[1] = int'(din[6:4]);   end
            if (we[1]) begin m_lvl[2] = int'(din[10:8]); m_lvl[3] = int'(din[14:12]); end
          end
          3'd3: begin
            if (we[0]) begin m_lvl[4] = int'(din[2:0]);  m_lvl[5] = int'(din[6:4]);   end
            if (we[1]) begin m_lvl[6] = int'(din[10:8]); m_lvl[7] = int'(din[14:12]); end
          end
          3'd4: if (we[0]) m_vbase = int'(din[7:5]);
          default: ;
        endcase
      end
      m_pend  = m_newp;
      m_edge  = m_first ? 8'h00 : (src & ~m_prev);
      m_prev  = src;
      m_first = 1'b0;
      m_ack   = m_access;
      st_q.push_back({16'(m_dout), m_irq, 3'(m_ilvl), 8'(m_iaddr)});
    end
  end

  // ---------------- monitor ----------------
  logic        mon_com, mon_st;
  logic [15:0] exp_rd;
  logic [27:0] exp_st;

  // Pop an expectation whenever the DUT completes an access or advances
  always @(posedge clk) begin
    mon_com = cs && (rd || we != 2'b00) && !busy && cen && !rst;
    mon_st  = rst || cen;
    #1;
    if (mon_com) begin
      if (rd_q.size() == 0) begin
        check("dout_unexpected_commit", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        exp_rd = rd_q.pop_front();
        check("dout", 32'(dout), 32'(exp_rd));
      end
    end
    if (mon_st) begin
      if (st_q.size() == 0) begin
        check("outputs_no_expectation", 32'({dout, irq, int_lvl, int_addr}), 32'hFFFF_FFFF);
      end else begin
        exp_st = st_q.pop_front();
        check("outputs", 32'({dout, irq, int_lvl, int_addr}), 32'(exp_st));
      end
    end
  end

  // busy is combinational: compare mid-cycle
  always @(negedge clk) begin
    if (!bench_done) check("busy", 32'(busy), 32'(cs && (rd || we != 2'b00) && !m_ack));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus(input logic [2:0] a, input logic [15:0] d, input logic [1:0] w,
                     input logic r, output logic [15:0] q, output int nbusy);
    logic done;
    int   n;
    cs = 1'b1; addr = a; din = d; we = w; rd = r;
    nbusy = 0; n = 0; done = 1'b0; q = '0;
    while (!done && n < 100) begin
      @(posedge clk);
      if (cen && !rst) begin
        if (busy) nbusy++;
        else done = 1'b1;
      end
      n++;
      #1;
      q = dout;
      #1;
    end
    cs = 1'b0; we = 2'b00; rd = 1'b0;
    check("bus_completes", 32'(done), 32'd1);
    tick();
  endtask

  logic [15:0] q;
  int          nb, n;
  bit          got;

  initial begin
    rst = 1'b1; cen = 1'b1; cs = 1'b0; rd = 1'b0; we = 2'b00;
    addr = '0; din = '0; src = '0; irq_ack = 1'b0;
    repeat (3) tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_int_addr", 32'(int_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // bus timing
    bus(3'd1, 16'h00FF, 2'b01, 1'b0, q, nb);
    check("wr_wait_states", 32'(nb), 32'd1);
    bus(3'd1, 16'h0000, 2'b00, 1'b1, q, nb);
    check("rd_wait_states", 32'(nb), 32'd1);
    check("rd_en", 32'(q), 32'h00FF);

    // latency and vector
    bus(3'd2, 16'h0500, 2'b10, 1'b0, q, nb);
    bus(3'd4, 16'h00A0, 2'b01, 1'b0, q, nb);
    src = 8'h04; n = 0; got = 1'b0;
    while (!got && n < 10) begin
      tick();
      src = 8'h00;
      n++;
      if (irq) got = 1'b1;
    end
    check("irq_latency", 32'(n), 32'd3);
    check("lat_int_lvl", 32'(int_lvl), 32'd5);
    check("lat_int_addr", 32'(int_addr), 32'hA8);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_drops_irq", 32'(irq), 32'd0);

    // priority
    bus(3'd2, 16'h0530, 2'b11, 1'b0, q, nb);
    bus(3'd3, 16'h0600, 2'b11, 1'b0, q, nb);
    src = 8'h42; tick(); src = 8'h00; tick(); tick();
    check("prio_irq", 32'(irq), 32'd1);
    check("prio_lvl", 32'(int_lvl), 32'd6);
    check("prio_addr", 32'(int_addr), 32'hB8);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("prio2_lvl", 32'(int_lvl), 32'd3);
    check("prio2_addr", 32'(int_addr), 32'hA4);
    bus(3'd5, 16'h0000, 2'b00, 1'b1, q, nb);
    check("stat", 32'(q), 32'h00EC);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("prio_done", 32'(irq), 32'd0);

    // tie on equal level
    bus(3'd2, 16'h0004, 2'b11, 1'b0, q, nb);
    bus(3'd3, 16'h0004, 2'b11, 1'b0, q, nb);
    src = 8'h11; tick(); src = 8'h00; tick(); tick();
    check("tie_first_addr", 32'(int_addr), 32'hA0);
    check("tie_first_lvl", 32'(int_lvl), 32'd4);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("tie_second_irq", 32'(irq), 32'd1);
    check("tie_second_addr", 32'(int_addr), 32'hB0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("tie_done", 32'(irq), 32'd0);

    // clear-versus-set race on PEND[3]
    src = 8'h08;
    bus(3'd0, 16'h0008, 2'b01, 1'b0, q, nb);
    src = 8'h00;
    bus(3'd0, 16'h0000, 2'b00, 1'b1, q, nb);
    check("race_pend", 32'(q), 32'h0008);

    // reset in the middle of an access while irq is high
    bus(3'd2, 16'h2004, 2'b11, 1'b0, q, nb);
    tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    check("pre_rst_addr", 32'(int_addr), 32'hAC);
    src = 8'hFF; cs = 1'b1; rd = 1'b1; addr = 3'd0;
    #1;
    check("access_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_busy", 32'(busy), 32'd1);
    tick();
    check("fresh_wait_done", 32'(busy), 32'd0);
    tick();
    check("post_rst_pend", 32'(dout), 32'd0);
    cs = 1'b0; rd = 1'b0;
    #1;
    check("busy_follows_cs", 32'(busy), 32'd0);
    tick();
    for (int a = 0; a < 5; a++) begin
      bus(3'(a), 16'h0000, 2'b00, 1'b1, q, nb);
      check("post_rst_read", 32'(q), 32'd0);
    end
    src = 8'h00;

    // randomized traffic
    fork
      begin
        for (int c = 0; c < 4000; c++) begin
          tick();
          cen     = ($urandom_range(0, 3) != 0);
          src     = src ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255) & $urandom_range(0, 255));
          irq_ack = ($urandom_range(0, 2) == 0);
          rst     = ($urandom_range(0, 599) == 0);
        end
        rnd_done = 1'b1;
      end
      begin
        logic [1:0] w;
        logic       r;
        logic [15:0] rq;
        int          rnb;
        while (!rnd_done) begin
          w = 2'($urandom_range(0, 3));
          r = (w == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
          bus(3'($urandom_range(0, 7)), 16'($urandom), w, r, rq, rnb);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join
    cen = 1'b1; rst = 1'b0; irq_ack = 1'b0;
    repeat (5) tick();
    bench_done = 1'b1;
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jt900h_intc.md
JT900H_INTC -- requirements
Module: jt900h_intc

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, and SHALL provide the following ports.
- rst       in   1   synchronous active-high reset
- clk       in   1   clock
- cen       in   1   clock enable; all state advances only when cen=1
- cs        in   1   chip select from the CPU address decode
- addr      in   3   CPU word address bits [3:1]
- din       in   16  CPU write data
- dout      out  16  read data, registered
- we        in   2   byte write enables: [0] selects din[7:0], [1] selects din[15:8]
- rd        in   1   read strobe
- busy      out  1   bus wait request
- src       in   8   interrupt sources, rising-edge sensitive
- irq       out  1   interrupt request to the CPU
- irq_ack   in   1   acknowledge from the CPU, one cen cycle wide
- int_lvl   out  3   level of the requested interrupt
- int_addr  out  8   vector address of the requested interrupt

Function
REQ-002 The register map, indexed by addr, SHALL be:
- 0: PEND[7:0], pending bits; read only, except that writing 1 to a bit clears it.
- 1: EN[7:0], per-source enable.
- 2: LVL for sources 0-3, one 3-bit field per source at bits [2:0], [6:4], [10:8] and [14:12].
- 3: LVL for sources 4-7, same field layout.
- 4: VBASE[7:5]; all other bits read as 0.
- 5: STAT, read only: {8'h0, irq, svc_idx[2:0], svc_lvl[2:0], 1'b0}.
- 6-7: read as 0; writes are ignored.
REQ-003 Writes SHALL honour we per byte; bits that are unused or read only SHALL ignore writes.
REQ-004 Bus handshake, given an access when cs & (rd | |we):
- busy SHALL be combinationally high until the internal ack_q register is set.
- ack_q SHALL set on the first cen cycle of the access, so every access has exactly one wait state.
REQ-005 The write SHALL commit, and dout SHALL load, on the cen cycle in which ack_q=1 and busy=0.
REQ-006 ack_q SHALL clear when cs=0 or when the strobes drop; back-to-back accesses SHALL each take one wait state.
REQ-007 Edge detection: src SHALL be registered each cen cycle, and src & ~src_q SHALL set the corresponding PEND bit on the next cen cycle.
REQ-008 A source is a candidate when its PEND=1, its EN=1 and its LVL≠0.
REQ-009 The winner SHALL be the candidate with the highest LVL; ties SHALL go to the lowest source index.
REQ-010 irq, int_lvl and int_addr SHALL be registered each cen cycle from the winner.
- int_addr SHALL be {VBASE[7:5], idx[2:0], 2'b00}.
- With no candidate: irq=0 and int_lvl=0, and int_addr SHALL hold its last value.
REQ-011 Latency from a src rising edge to irq high SHALL be 3 cen cycles: sample, then PEND set, then irq set.
REQ-012 On a cen cycle with irq_ack=1 and irq=1:
- The PEND bit of the current output index SHALL clear.
- svc_idx and svc_lvl SHALL latch that index and level.
- irq SHALL re-evaluate on the next cen cycle, without the acknowledged source.
REQ-013 irq_ack while irq=0 SHALL be ignored.
REQ-014 Simultaneous events SHALL be resolved as follows:
- An edge on a source coincides with a write-1-clear or an ack of the same bit: the set SHALL win and PEND stays 1.
- Two sources with equal level have edges in the same cycle: both SHALL pend, and the lower index SHALL be served first.
REQ-015 Disabling a source (EN=0 or LVL=0) SHALL NOT clear its PEND bit; it SHALL only stop that source from being a candidate.
REQ-016 With cen=0 no register SHALL change; busy SHALL still follow REQ-004 combinationally.

Reset
REQ-017 While rst=1 on a clock edge, regardless of cen, the following SHALL clear to 0: PEND, EN, LVL, VBASE, svc_idx, svc_lvl, src_q, ack_q, dout, irq, int_lvl and int_addr.
REQ-018 src_q SHALL load src on the first cen cycle after reset, so that a source held high through reset does not pend.
REQ-019 A bus access in progress at reset SHALL be aborted; after reset it SHALL restart with a fresh wait state.

Verification
REQ-020 The bench SHALL cover the following scenarios:
- Bus timing: write EN=8'hFF (we=2'b01), then read addr 1 -> busy high for exactly 1 cen cycle per access; dout=16'h00FF.
- Latency and vector: LVL src2=5, VBASE=8'hA0, EN bit 2 set, then pulse src[2] -> irq=1 three cen cycles later, int_lvl=5, int_addr=8'hA8.
- Priority: src1 at LVL 3 and src6 at LVL 6 pend together -> int_lvl=6, int_addr index 6; after ack -> int_lvl=3, index 1, STAT svc_idx=6.
- Tie: src0 and src4 both at LVL 4 have edges in the same cycle -> index 0 first, then index 4.
- Clear-versus-set race: write PEND=8'h08 in the same cen cycle as a src[3] edge -> PEND[3] stays 1.
- Reset: assert rst mid-access while irq=1 -> irq=0, busy follows cs; read addr 0..4 -> all 0.
